ht_cmd_gate: RTL

HT_CMD_GATE -- requirements
Module: ht_cmd_gate

---
 rtl/hash_table_pkg.sv | 19 +
 rtl/ht_cmd_gate_fifo.sv | 75 +++++++
 rtl/ht_cmd_gate.sv | 109 ++++++++++
 3 files changed

// File: rtl/hash_table_pkg.sv
// Shared hash-table types: the command word, its opcode enum and field widths.
package hash_table;

  localparam int KEY_WIDTH   = 16;
  localparam int VALUE_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t             op;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

endpackage

// File: rtl/ht_cmd_gate_fifo.sv
// Synchronous command FIFO with registered full/empty flags and a used count.
// The read word is presented from the head entry whenever the FIFO is not
// empty; it only changes on a pop, so a stalled consumer sees stable data.
module ht_cmd_gate_fifo
  import hash_table::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_wr_en,
  input  ht_command_t                i_wr_data,
  input  logic                       i_rd_en,
  output ht_command_t                o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_used
);

  localparam int AW = $clog2(DEPTH);

  ht_command_t    r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_used;
  logic           r_full;
  logic           r_empty;

  logic           w_push;
  logic           w_pop;
  logic [AW:0]    w_used_nxt;

  // Qualify requests with the registered flags: no write when full, and a
  // word written into an empty FIFO cannot be read in the same cycle.
  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_used_nxt = r_used;
    case ({w_push, w_pop})
      2'b10:   w_used_nxt = r_used + 1'b1;
      2'b01:   w_used_nxt = r_used - 1'b1;
      default: w_used_nxt = r_used;
    endcase
  end

  // Pointers, count and flags; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_used  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_used  <= w_used_nxt;
      r_full  <= (w_used_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_used_nxt == '0);
    end
  end

  // Storage array; contents need no reset since the flags guard every read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_used    = r_used;

endmodule

// File: rtl/ht_cmd_gate.sv
// Command gate in front of the hash engine: buffers upstream commands and
// only issues while fewer than MAX_INFLIGHT results are outstanding.
// Optional per-opcode issue statistics with macro HT_CMD_GATE_STAT_EN.
module ht_cmd_gate
  import hash_table::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  ht_command_t                   cmd_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  output ht_command_t                   ht_cmd_o,
  output logic                          ht_cmd_valid_o,
  input  logic                          ht_cmd_ready_i,
  input  logic                          ht_res_valid_i,
  output logic [3:0]                    inflight_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_used_o,
  output logic                          idle_o,
`ifdef HT_CMD_GATE_STAT_EN
  input  logic                          stat_clr_i,
  output logic [31:0]                   stat_search_o,
  output logic [31:0]                   stat_insert_o,
  output logic [31:0]                   stat_delete_o,
`endif
  output logic                          credit_err_o
);

  logic [3:0]  r_inflight;
  logic        r_credit_err;

  logic        w_full;
  logic        w_empty;
  logic        w_issue;
  logic        w_credit_ok;
  ht_command_t w_head;

  ht_cmd_gate_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_wr_en   (cmd_valid_i),
    .i_wr_data (cmd_i),
    .i_rd_en   (w_issue),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_used    (fifo_used_o)
  );

  // Inflight only decreases between issues, so once valid rises it holds
  // until the engine takes the head word.
  assign w_credit_ok    = (r_inflight < 4'(MAX_INFLIGHT));
  assign ht_cmd_valid_o = !w_empty && w_credit_ok;
  assign ht_cmd_o       = w_head;
  assign w_issue        = ht_cmd_valid_o && ht_cmd_ready_i;
  assign cmd_ready_o    = !w_full;

  // Outstanding-command counter; an unmatched result at zero is flagged sticky.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight   <= '0;
      r_credit_err <= 1'b0;
    end else begin
      case ({w_issue, ht_res_valid_i})
        2'b10: r_inflight <= r_inflight + 1'b1;
        2'b01: begin
          if (r_inflight == '0) r_credit_err <= 1'b1;
          else                  r_inflight   <= r_inflight - 1'b1;
        end
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign inflight_o   = r_inflight;
  assign credit_err_o = r_credit_err;
  assign idle_o       = w_empty && (r_inflight == '0);

`ifdef HT_CMD_GATE_STAT_EN
  logic [31:0] r_stat_search;
  logic [31:0] r_stat_insert;
  logic [31:0] r_stat_delete;

  // Per-opcode issue counters, saturating; clear overrides a same-cycle count.
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      r_stat_search <= '0;
      r_stat_insert <= '0;
      r_stat_delete <= '0;
    end else if (w_issue) begin
      case (w_head.op)
        OP_SEARCH: if (r_stat_search != '1) r_stat_search <= r_stat_search + 1'b1;
        OP_INSERT: if (r_stat_insert != '1) r_stat_insert <= r_stat_insert + 1'b1;
        OP_DELETE: if (r_stat_delete != '1) r_stat_delete <= r_stat_delete + 1'b1;
        default:   ;
      endcase
    end
  end

  assign stat_search_o = r_stat_search;
  assign stat_insert_o = r_stat_insert;
  assign stat_delete_o = r_stat_delete;
`endif

endmodule
